// File: rtl/inverse_roundconst_pkg.sv
// Shared definitions for the inverse JH round-constant block.
// Provides the nibble type, nibble-count constants, the GF(16)
// multiply-by-2 helper and the controller state encoding.
package inverse_roundconst_pkg;

  localparam int unsigned NIB  = 4;
  localparam int unsigned NNIB = 64;

  typedef logic [NIB-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // Multiply by x in GF(16) modulo x^4 + x + 1.
  function automatic nibble_t gf16_mul2(input nibble_t x);
    return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
  endfunction

endpackage

// File: rtl/inverse_roundconst_step.sv
// inv_roundconst_step: one combinational inverse JH round-constant step.
//   round_in  [255:0] : constant C_r, nibble i at [4i+3:4i]
//   S_box_inv [63:0]  : inverse S-box, entry i at [4i+3:4i]
//   round_out [255:0] : constant C_(r-1), same packing
// Swap/permutation undo stages are pure wiring; only the L undo and the
// S-box lookup produce logic.
module inv_roundconst_step
  import inverse_roundconst_pkg::*;
(
  input  logic [NNIB*NIB-1:0] round_in,
  input  logic [63:0]         S_box_inv,
  output logic [NNIB*NIB-1:0] round_out
);

  nibble_t p [NNIB];
  nibble_t a [NNIB];
  nibble_t q [NNIB];
  nibble_t c [NNIB];
  nibble_t y [NNIB];

  for (genvar j = 0; j < NNIB; j++) begin : g_wire
    assign p[j] = round_in[NIB*j +: NIB];

    // Undo final swap: upper half swaps adjacent pairs.
    if (j >= NNIB/2) begin : g_fs
      assign a[j] = p[j ^ 1];
    end else begin : g_fk
      assign a[j] = p[j];
    end

    // Undo initial swap: elements 2 and 3 of each group of four.
    if ((j % 4) >= 2) begin : g_is
      assign c[j] = q[j ^ 1];
    end else begin : g_ik
      assign c[j] = q[j];
    end
  end

  // Undo permutation: interleave lower and upper halves.
  for (genvar i = 0; i < NNIB/2; i++) begin : g_perm
    assign q[2*i]   = a[i];
    assign q[2*i+1] = a[i + NNIB/2];
  end

  // Undo L: y0 must be formed first because y1 depends on it.
  for (genvar i = 0; i < NNIB/2; i++) begin : g_l
    assign y[2*i]   = c[2*i]   ^ gf16_mul2(c[2*i+1]);
    assign y[2*i+1] = c[2*i+1] ^ gf16_mul2(y[2*i]);
  end

  for (genvar i = 0; i < NNIB; i++) begin : g_sbox
    assign round_out[NIB*i +: NIB] = S_box_inv[{y[i], 2'b00} +: NIB];
  end

endmodule

// File: rtl/inverse_roundconst.sv
// inverse_roundconst: steps a JH round constant backwards N rounds.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : request, sampled when not busy (also in FIN)
//   num_rounds      : number of inverse steps N, sampled with start
//   const_in        : starting constant C_r, sampled with start
//   S_box_inv       : inverse S-box, held stable while busy
//   const_out       : working/result register
//   busy            : steps remain
//   done            : one-cycle pulse, const_out valid
//   rounds_left     : remaining steps
module inverse_roundconst
  import inverse_roundconst_pkg::*;
#(
  parameter int unsigned ROUNDS_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ROUNDS_W-1:0] num_rounds,
  input  logic [255:0]        const_in,
  input  logic [63:0]         S_box_inv,
  output logic [255:0]        const_out,
  output logic                busy,
  output logic                done,
  output logic [ROUNDS_W-1:0] rounds_left
);

  state_t       state, state_nxt;
  logic         load, step_en;
  logic [255:0] step_out;

  inv_roundconst_step u_step (
    .round_in  (const_out),
    .S_box_inv (S_box_inv),
    .round_out (step_out)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    unique case (state)
      IDLE, FIN: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (num_rounds == '0) ? FIN : RUN;
        end else if (state == FIN) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (rounds_left == ROUNDS_W'(1)) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      const_out   <= '0;
      rounds_left <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        const_out   <= const_in;
        rounds_left <= num_rounds;
      end else if (step_en) begin
        const_out   <= step_out;
        rounds_left <= rounds_left - ROUNDS_W'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_inverse_roundconst.sv
module tb_inverse_roundconst;

  localparam logic [255:0] C0 =
    256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;
  localparam logic [63:0] S0_TAB   = 64'hE857_62A1_F3CD_B409;
  localparam logic [63:0] SINV_TAB = 64'h7F45_390E_CBD2_6A81;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [5:0]   num_rounds;
  logic [255:0] const_in;
  logic [63:0]  S_box_inv;
  logic [255:0] const_out;
  logic         busy, done;
  logic [5:0]   rounds_left;

  inverse_roundconst #(.ROUNDS_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_rounds  (num_rounds),
    .const_in    (const_in),
    .S_box_inv   (S_box_inv),
    .const_out   (const_out),
    .busy        (busy),
    .done        (done),
    .rounds_left (rounds_left)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] exp;
    longint       due;
  } sb_t;
  sb_t sb[$];

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden forward round-constant update.
  function automatic logic [3:0] m2(input logic [3:0] v);
    logic [4:0] t;
    t = {v, 1'b0};
    if (t[4]) t = t ^ 5'b10011;
    return t[3:0];
  endfunction

  function automatic logic [255:0] fwd(input logic [255:0] x);
    logic [3:0] s [64];
    logic [3:0] l [64];
    logic [3:0] w [64];
    logic [3:0] v [64];
    logic [255:0] o;
    logic [63:0] tab;
    int idx;
    tab = S0_TAB;
    for (int i = 0; i < 64; i++) begin
      idx  = int'(x[4*i +: 4]);
      s[i] = tab[4*idx +: 4];
    end
    for (int i = 0; i < 32; i++) begin
      l[2*i+1] = s[2*i+1] ^ m2(s[2*i]);
      l[2*i]   = s[2*i]   ^ m2(l[2*i+1]);
    end
    for (int j = 0; j < 64; j++) w[j] = ((j % 4) >= 2) ? l[j ^ 1] : l[j];
    for (int i = 0; i < 32; i++) begin
      v[i]      = w[2*i];
      v[i + 32] = w[2*i+1];
    end
    for (int j = 0; j < 64; j++) o[4*j +: 4] = (j >= 32) ? v[j ^ 1] : v[j];
    return o;
  endfunction

  function automatic logic [255:0] fwdn(input logic [255:0] x, input int n);
    logic [255:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = fwd(r);
    return r;
  endfunction

  // Completion monitor: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        chk("result", const_out, e.exp);
        chk("done_cycle", 256'(cyc), 256'(e.due));
        chk("rounds_left_done", 256'(rounds_left), 256'(0));
        chk("busy_at_done", 256'(busy), 256'(0));
      end
    end
  end

  task automatic issue(input logic [255:0] din, input int n, input logic [255:0] exp);
    sb_t e;
    start      = 1'b1;
    const_in   = din;
    num_rounds = 6'(n);
    e.exp      = exp;
    e.due      = cyc + longint'(n) + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_timeout", 256'(sb.size()), 256'(0));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("done_timeout", 256'(done), 256'(1));
  endtask

  initial begin
    logic [255:0] x;
    int n, cnt, g;

    rst_n = 1'b0; start = 1'b0; num_rounds = '0; const_in = '0;
    S_box_inv = SINV_TAB;
    repeat (2) @(negedge clk);
    chk("rst_const_out", const_out, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_rounds_left", 256'(rounds_left), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // N=1
    issue(fwd(C0), 1, C0);
    wait_drain();

    // N=0: busy never rises
    issue(C0, 0, C0);
    chk("n0_busy", 256'(busy), 256'(0));
    wait_drain();
    @(negedge clk);

    // N=42 with an ignored start pulse mid-run
    x = fwdn(C0, 42);
    issue(x, 42, C0);
    cnt = 0; g = 0;
    while (!done && g < 100) begin
      if (busy) cnt++;
      if (g == 3) begin
        start = 1'b1; const_in = ~x; num_rounds = 6'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    chk("n42_busy_cycles", 256'(cnt), 256'(42));
    wait_drain();
    @(negedge clk);
    chk("idle_after_done", 256'(done), 256'(0));
    chk("hold_const_out", const_out, C0);

    // Reset mid-run: outputs clear, no done pulse afterwards
    issue(fwdn(C0, 42), 42, C0);
    repeat (8) @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_const_out", const_out, 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_done", 256'(done), 256'(0));
    chk("abort_rounds_left", 256'(rounds_left), 256'(0));
    repeat (60) @(negedge clk);
    x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    issue(fwd(x), 1, x);
    wait_drain();
    @(negedge clk);

    // Random sweep, two of every three issued back-to-back in the FIN cycle
    for (int t = 0; t < 200; t++) begin
      if (t % 3 != 0) begin
        wait_done();
      end else begin
        wait_drain();
        @(negedge clk);
      end
      x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      n = int'($urandom_range(1, 63));
      issue(fwdn(x, n), n, x);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/inverse_roundconst.md
# inverse_roundconst

Sequential inverse of the JH round-constant update: given a round constant C_r and a round count N, it steps the constant backwards one round per clock and returns C_(r-N). Each step is the exact inverse of the forward update: undo final swap, undo permutation, undo initial swap, undo the L transform, then the inverse S-box. The block sits beside the forward constant generator. Two uses:
- rewinding constants in a decryption/self-test path;
- round-trip checking of the forward generator in system tests.

## Interface
- ROUNDS_W, 6, width of the round-count input and counter (max 2^ROUNDS_W-1 steps; JH needs 42).

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- num_rounds  in  ROUNDS_W  number of inverse steps N; sampled with start.
- const_in  in  256  constant C_r; nibble i at [4i+3:4i]; sampled with start.
- S_box_inv  in  64  inverse of the forward S-box; entry i at [4i+3:4i]; must stay stable while busy=1.
- const_out  out  256  working/result register; same nibble packing as const_in.
- busy  out  1  high while steps remain.
- done  out  1  one-cycle pulse; const_out is valid in that cycle.
- rounds_left  out  ROUNDS_W  remaining steps.

## Operation
- f(x) on a nibble is multiply-by-2 in GF(16) mod x^4+x+1: {x[2:0],0} ^ {00,x[3],x[3]}.
- One inverse step on 64 nibbles p[0..63]:
  - a. Undo final swap: for even j ≥ 32, swap p[j] and p[j+1]; p[0..31] unchanged.
  - b. Undo permutation: q[2i] = a[i] and q[2i+1] = a[i+32], for i = 0..31.
  - c. Undo initial swap: in each group of four starting at 4k, swap elements 4k+2 and 4k+3.
  - d. Undo L, per even pair (x0 = c[2i], x1 = c[2i+1]): y0 = x0 ^ f(x1), then y1 = x1 ^ f(y0).
  - e. Substitute: out[i] = S_box_inv[y[i]].
- FSM states:
  - IDLE: on start, load const_out <= const_in and rounds_left <= num_rounds. If num_rounds = 0, go to FIN; otherwise go to RUN with busy=1.
  - RUN: each cycle, const_out <= step(const_out) and rounds_left decrements. When rounds_left = 1, the final step completes and the FSM goes to FIN.
  - FIN: done=1 and busy=0 for one cycle, then IDLE. A start sampled in FIN is accepted, so a back-to-back start is allowed.
- start is ignored while busy=1; the request is not queued.
- const_out holds its value after done until the next accepted start.
- No arithmetic beyond the ROUNDS_W-bit decrement. Underflow is impossible because RUN is never entered with rounds_left = 0.

## Timing
- Reset (rst_n=0 at an edge) forces IDLE with busy=0, done=0, const_out=0 and rounds_left=0. This applies mid-operation too: the run is aborted and no done pulse is produced.
- start accepted in cycle k: busy=1 from k+1 to k+N and done=1 in cycle k+N+1. For N=0, done=1 in cycle k+1 and busy never rises.
- Combinational depth per step: one S-box mux plus two chained f/XOR stages. Steps a-c are wiring only.
- The S_box_inv value is used combinationally every RUN cycle. Changing it mid-run is illegal and produces undefined results.

## Structure
- Shared package holds:
  - nibble type and the NIB=4 and NNIB=64 constants;
  - a gf16_mul2 function;
  - FSM state enum {IDLE, RUN, FIN}.
- Sub-module inv_roundconst_step: a purely combinational single inverse step with ports (round_in, S_box_inv, round_out). The top level is the FSM, counter and register around it.

## Test plan
- Inverse S-box used throughout: nibbles 0..15 = 1,8,10,6,2,13,11,12,14,0,9,3,5,4,15,7, the inverse of S0 = 9,0,4,11,13,12,3,15,1,10,2,6,7,5,8,14. C0 = 6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a.
- N=1: const_in = forward(C0) from the golden model -> done at k+2, const_out = C0.
- N=42: const_in = forward^42(C0) -> busy for 42 cycles, done at k+43, const_out = C0, rounds_left = 0.
- N=0: const_in = C0 -> done at k+1, const_out = C0, busy stays 0.
- Pulse start again at cycle k+5 during the N=42 run with different data -> ignored; result still C0.
- Reset at cycle k+10 of the N=42 run -> next cycle all outputs are 0 and no done pulse follows. A new N=1 start afterwards completes correctly.
- Random sweep: 200 random 256-bit X with random N in 1..63. Feed forward^N(X) -> const_out = X, done exactly N+1 cycles after start. Include back-to-back starts issued in the FIN cycle.
